// File: rtl/c3_heap_pkg.sv
// Shared opcodes, default geometry and key type for the C3 min-priority-queue unit.
// Pure declarations; no timing or backpressure of its own.
package c3_heap_pkg;

  localparam logic [4:0] OP_PUSH = 5'd0;
  localparam logic [4:0] OP_POP  = 5'd1;
  localparam logic [4:0] OP_PEEK = 5'd2;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_DATA_W = 32;

  typedef logic [DEF_DATA_W-1:0] key_t;

endpackage

// File: rtl/c3_sorted_queue.sv
// Sorted-ascending register array with count; entry 0 is always the minimum.
// Updates on the edge after push/pop; caller must not push when full or pop when empty.
module c3_sorted_queue
  import c3_heap_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] q     [DEPTH];
  logic [DATA_W-1:0] q_nxt [DEPTH];
  logic [CW-1:0]     cnt;
  logic [DEPTH-1:0]  gt;
  logic [DEPTH-1:0]  gt_prev;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = q[0];

  // Strict greater-than keeps equal keys in arrival order.
  always_comb begin
    gt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gt[i] = (CW'(i) < cnt) && (q[i] > din);
    end
  end

  if (DEPTH > 1) begin : g_prev
    assign gt_prev = {gt[DEPTH-2:0], 1'b0};
  end else begin : g_prev1
    assign gt_prev = '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = q[i];
    end
    if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!gt_prev[i] && (gt[i] || (CW'(i) == cnt))) q_nxt[i] = din;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (gt_prev[i]) q_nxt[i] = q[i-1];
      end
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_nxt[i] = q[i+1];
      end
    end
  end

  // Key storage needs no reset: cnt alone defines which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      q[i] <= q_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/c3_custom_simd_instruction.sv
// Min-priority-queue custom instruction (PUSH/POP, PEEK when C3_HEAP_PEEK_EN is defined); 1-cycle registered result.
// No backpressure: every edge executes the opcode on rd; full push / empty pop report out_v=0.
module c3_custom_simd_instruction
  import c3_heap_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rd,
  input  logic [2:0]        vrd1,
  input  logic [2:0]        vrd2,
  input  logic [DATA_W-1:0] in_data,
  input  logic [127:0]      in_vdata1,
  input  logic [127:0]      in_vdata2,
  output logic              out_v,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_vrd1,
  output logic [2:0]        out_vrd2,
  output logic [DATA_W-1:0] out_data,
  output logic [127:0]      out_vdata1,
  output logic [127:0]      out_vdata2
);

  logic              push;
  logic              pop;
  logic              peek;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              res_v;
  logic [DATA_W-1:0] res_data;

  assign push = (rd == OP_PUSH);
  assign pop  = (rd == OP_POP);
`ifdef C3_HEAP_PEEK_EN
  assign peek = (rd == OP_PEEK);
`else
  assign peek = 1'b0;
`endif

  c3_sorted_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    res_v    = 1'b0;
    res_data = '0;
    if (push && !full) begin
      res_v    = 1'b1;
      res_data = DATA_W'(count) + DATA_W'(1);
    end else if ((pop || peek) && !empty) begin
      res_v    = 1'b1;
      res_data = head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v      <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      out_vrd1   <= '0;
      out_vrd2   <= '0;
      out_vdata1 <= '0;
      out_vdata2 <= '0;
    end else begin
      out_v      <= res_v;
      out_data   <= res_data;
      out_rd     <= rd;
      out_vrd1   <= vrd1;
      out_vrd2   <= vrd2;
      out_vdata1 <= in_vdata1;
      out_vdata2 <= in_vdata2;
    end
  end

endmodule

// File: tb/tb_c3_custom_simd_instruction.sv
// Directed bench for the C3 min-priority-queue instruction unit.
module tb_c3_custom_simd_instruction;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   rd;
  logic [2:0]   vrd1, vrd2;
  logic [31:0]  in_data;
  logic [127:0] in_vdata1, in_vdata2;
  logic         out_v;
  logic [4:0]   out_rd;
  logic [2:0]   out_vrd1, out_vrd2;
  logic [31:0]  out_data;
  logic [127:0] out_vdata1, out_vdata2;

  int total = 0;
  int bad   = 0;

  c3_custom_simd_instruction dut (
    .clk        (clk),
    .reset      (reset),
    .rd         (rd),
    .vrd1       (vrd1),
    .vrd2       (vrd2),
    .in_data    (in_data),
    .in_vdata1  (in_vdata1),
    .in_vdata2  (in_vdata2),
    .out_v      (out_v),
    .out_rd     (out_rd),
    .out_vrd1   (out_vrd1),
    .out_vrd2   (out_vrd2),
    .out_data   (out_data),
    .out_vdata1 (out_vdata1),
    .out_vdata2 (out_vdata2)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [4:0] op, input logic [31:0] d);
    @(negedge clk);
    rd      = op;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; rd = 5'd9; vrd1 = '0; vrd2 = '0;
    in_data = '0; in_vdata1 = '0; in_vdata2 = '0;
    #12;
    total++;
    if (out_v !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0) begin
      bad++;
      $display("FAIL reset_init: v=%b data=%h rd=%h want 0", out_v, out_data, out_rd);
    end
    @(negedge clk);
    reset = 1'b0;
    do_op(5'd0, 32'd100);
    do_op(5'd0, 32'd200);
    do_op(5'd0, 32'd300);
    total++;
    if (out_v !== 1'b1 || out_data !== 32'd3) begin
      bad++;
      $display("FAIL reset_prefill: v=%b data=%0d want v=1 data=3", out_v, out_data);
    end
    vrd1 = 3'd5; vrd2 = 3'd6; in_vdata1 = {4{32'hDEADBEEF}}; in_vdata2 = {4{32'h12345678}};
    do_op(5'd9, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_v !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0 || out_vrd1 !== 3'd0 ||
        out_vrd2 !== 3'd0 || out_vdata1 !== 128'd0 || out_vdata2 !== 128'd0) begin
      bad++;
      $display("FAIL reset_async: v=%b data=%h rd=%h vrd=%h/%h vd1=%h want all 0",
               out_v, out_data, out_rd, out_vrd1, out_vrd2, out_vdata1);
    end
    vrd1 = '0; vrd2 = '0; in_vdata1 = '0; in_vdata2 = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(5'd1, 32'd0);
    total++;
    if (out_v !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd1) begin
      bad++;
      $display("FAIL reset_pop_empty: v=%b data=%h rd=%h want v=0 data=0 rd=1", out_v, out_data, out_rd);
    end
  endtask

  task automatic test_ordered_pop;
    logic [31:0] keys [4] = '{32'd50, 32'd10, 32'd30, 32'd10};
    logic [31:0] pops [4] = '{32'd10, 32'd10, 32'd30, 32'd50};
    for (int i = 0; i < 4; i++) begin
      do_op(5'd0, keys[i]);
      total++;
      if (out_v !== 1'b1 || out_data !== 32'(i + 1)) begin
        bad++;
        $display("FAIL ordered_push%0d: v=%b data=%0d want v=1 data=%0d", i, out_v, out_data, i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_op(5'd1, 32'd0);
      total++;
      if (out_v !== 1'b1 || out_data !== pops[i]) begin
        bad++;
        $display("FAIL ordered_pop%0d: v=%b data=%0d want v=1 data=%0d", i, out_v, out_data, pops[i]);
      end
    end
    do_op(5'd1, 32'd0);
    total++;
    if (out_v !== 1'b0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL ordered_pop_empty: v=%b data=%h want v=0 data=0", out_v, out_data);
    end
  endtask

  task automatic test_full;
    logic [31:0] exp_q [$];
    logic [31:0] k;
    int errs = 0;
    for (int i = 0; i < 32; i++) begin
      k = $urandom;
      if (k == 32'd7) k = 32'd8;
      exp_q.push_back(k);
      do_op(5'd0, k);
      if (out_v !== 1'b1 || out_data !== 32'(i + 1)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL full_fill: %0d push results wrong, last v=%b data=%0d want 32", errs, out_v, out_data);
    end
    do_op(5'd0, 32'd7);
    total++;
    if (out_v !== 1'b0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL full_push: v=%b data=%h want v=0 data=0", out_v, out_data);
    end
    exp_q.sort();
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      do_op(5'd1, 32'd0);
      if (out_v !== 1'b1 || out_data !== exp_q[i]) begin
        errs++;
        if (errs < 4)
          $display("FAIL full_pop%0d: v=%b data=%h want %h", i, out_v, out_data, exp_q[i]);
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic test_random_pairing;
    logic [31:0] exp_q [$];
    logic [31:0] k;
    int errs = 0;
    for (int i = 0; i < 25; i++) begin
      k = $random;
      exp_q.push_back(k);
      do_op(5'd0, k);
      if (out_rd !== 5'd0 || out_v !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rand_push: %0d bad results, last rd=%h v=%b want rd=0 v=1", errs, out_rd, out_v);
    end
    exp_q.sort();
    errs = 0;
    for (int i = 0; i < 25; i++) begin
      do_op(5'd1, 32'd0);
      if (out_rd !== 5'd1 || out_v !== 1'b1 || out_data !== exp_q[i]) begin
        errs++;
        if (errs < 4)
          $display("FAIL rand_pop%0d: rd=%h v=%b data=%h want rd=1 v=1 data=%h",
                   i, out_rd, out_v, out_data, exp_q[i]);
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic test_peek;
    do_op(5'd0, 32'hFFFF_FFFF);
    do_op(5'd0, 32'h0000_0001);
    for (int i = 0; i < 2; i++) begin
      do_op(5'd2, 32'd0);
      total++;
`ifdef C3_HEAP_PEEK_EN
      if (out_v !== 1'b1 || out_data !== 32'h1) begin
        bad++;
        $display("FAIL peek%0d: v=%b data=%h want v=1 data=1", i, out_v, out_data);
      end
`else
      if (out_v !== 1'b0 || out_data !== 32'h0) begin
        bad++;
        $display("FAIL peek_nop%0d: v=%b data=%h want v=0 data=0", i, out_v, out_data);
      end
`endif
    end
    do_op(5'd0, 32'd5);
    total++;
    if (out_v !== 1'b1 || out_data !== 32'd3) begin
      bad++;
      $display("FAIL peek_count: v=%b data=%0d want v=1 data=3", out_v, out_data);
    end
    do_op(5'd1, 32'd0);
    total++;
    if (out_v !== 1'b1 || out_data !== 32'h1) begin
      bad++;
      $display("FAIL peek_then_pop: v=%b data=%h want v=1 data=1", out_v, out_data);
    end
    do_op(5'd1, 32'd0);
    do_op(5'd1, 32'd0);
    total++;
    if (out_v !== 1'b1 || out_data !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL peek_drain: v=%b data=%h want v=1 data=ffffffff", out_v, out_data);
    end
  endtask

  task automatic test_pass_through;
    in_vdata1 = {16{8'hA5}};
    in_vdata2 = {8{16'h3C96}};
    vrd1 = 3'd1;
    vrd2 = 3'd3;
    do_op(5'd9, 32'd123);
    total++;
    if (out_vdata1 !== {16{8'hA5}} || out_vdata2 !== {8{16'h3C96}} || out_vrd1 !== 3'd1 ||
        out_vrd2 !== 3'd3 || out_rd !== 5'd9 || out_v !== 1'b0 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL pass_through: vd1=%h vd2=%h vrd1=%h vrd2=%h rd=%h v=%b data=%h",
               out_vdata1, out_vdata2, out_vrd1, out_vrd2, out_rd, out_v, out_data);
    end
  endtask

  task automatic test_back_to_back;
    do_op(5'd0, 32'h0BAD_F00D);
    do_op(5'd1, 32'd0);
    total++;
    if (out_v !== 1'b1 || out_data !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL back_to_back: v=%b data=%h want v=1 data=0badf00d", out_v, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_ordered_pop();
    test_full();
    test_random_pairing();
    test_peek();
    test_pass_through();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
